// File: rtl/snake_mem_scanner.sv
// rtl/snake_mem_scanner.sv - raster scan of the snake tile RAM into a tile stream
// Reads run at most two ahead of the consumer, so a 2-entry buffer never overflows.
module snake_mem_scanner #(
   parameter int COLS   = 38,
   parameter int ROWS   = 20,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_clken,
   output logic              mem_write,
   output logic [7:0]        mem_writedata,
   input  logic [7:0]        mem_readdata,
   output logic              tile_valid,
   input  logic              tile_ready,
   output logic [7:0]        tile_data,
   output logic [5:0]        tile_col,
   output logic [4:0]        tile_row,
   output logic              tile_sof,
   output logic              tile_eof
);

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

   typedef struct packed {
      logic [7:0] data;
      logic [5:0] col;
      logic [4:0] row;
   } entry_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] last_addr_q, last_addr_d;
   logic [5:0]        col_q, col_d, fl_col_q, fl_col_d;
   logic [4:0]        row_q, row_d, fl_row_q, fl_row_d;
   logic              inflight_q, inflight_d;
   logic [1:0]        cnt_q, cnt_d;
   entry_t            b0_q, b0_d, b1_q, b1_d, new_e;
   logic              done_q, done_d;
   logic              pop, push, issue, last_issue;
   logic [2:0]        occ;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         last_addr_q <= '0;
         col_q       <= '0;
         row_q       <= '0;
         fl_col_q    <= '0;
         fl_row_q    <= '0;
         inflight_q  <= 1'b0;
         cnt_q       <= '0;
         b0_q        <= '0;
         b1_q        <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         last_addr_q <= last_addr_d;
         col_q       <= col_d;
         row_q       <= row_d;
         fl_col_q    <= fl_col_d;
         fl_row_q    <= fl_row_d;
         inflight_q  <= inflight_d;
         cnt_q       <= cnt_d;
         b0_q        <= b0_d;
         b1_q        <= b1_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      last_addr_d = last_addr_q;
      col_d       = col_q;
      row_d       = row_q;
      fl_col_d    = fl_col_q;
      fl_row_d    = fl_row_q;
      cnt_d       = cnt_q;
      b0_d        = b0_q;
      b1_d        = b1_q;
      done_d      = 1'b0;

      pop        = tile_valid && tile_ready;
      push       = inflight_q;
      new_e      = '{data: mem_readdata, col: fl_col_q, row: fl_row_q};
      // Occupancy after this cycle's pop; issuing keeps buffer + in-flight within 2.
      occ        = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
      issue      = (state_q == S_SCAN) && !abort && (occ < 3'd2);
      last_issue = (addr_q == ADDR_W'(COLS * ROWS - 1));
      inflight_d = issue;

      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) b0_d = new_e;
            else               b1_d = new_e;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            b0_d  = b1_q;
            cnt_d = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               b0_d = new_e;
            end else begin
               b0_d = b1_q;
               b1_d = new_e;
            end
         end
         default: ;
      endcase

      if (issue) begin
         fl_col_d    = col_q;
         fl_row_d    = row_q;
         last_addr_d = addr_q;
         if (!last_issue) addr_d = addr_q + ADDR_W'(1);
         if (col_q == 6'(COLS - 1)) begin
            col_d = '0;
            row_d = row_q + 5'd1;
         end else begin
            col_d = col_q + 6'd1;
         end
      end

      case (state_q)
         S_IDLE: begin
            if (start && !abort) begin
               state_d    = S_SCAN;
               addr_d     = '0;
               col_d      = '0;
               row_d      = '0;
               cnt_d      = '0;
               inflight_d = 1'b0;
            end
         end
         S_SCAN: begin
            if (issue && last_issue) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (pop && tile_eof) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (abort && (state_q != S_IDLE)) begin
         state_d    = S_IDLE;
         cnt_d      = '0;
         inflight_d = 1'b0;
         done_d     = 1'b0;
      end
   end

   assign busy           = (state_q != S_IDLE);
   assign done           = done_q;
   assign mem_chipselect = issue;
   assign mem_address    = issue ? addr_q : last_addr_q;
   assign mem_clken      = 1'b1;
   assign mem_write      = 1'b0;
   assign mem_writedata  = 8'h00;
   assign tile_valid     = (cnt_q != 2'd0);
   assign tile_data      = b0_q.data;
   assign tile_col       = b0_q.col;
   assign tile_row       = b0_q.row;
   assign tile_sof       = tile_valid && (b0_q.col == 6'd0) && (b0_q.row == 5'd0);
   assign tile_eof       = tile_valid && (b0_q.col == 6'(COLS - 1)) && (b0_q.row == 5'(ROWS - 1));

endmodule

// File: tb/tb_snake_mem_scanner.sv
// tb/tb_snake_mem_scanner.sv - scoreboard bench for snake_mem_scanner
module tb_snake_mem_scanner;
   localparam int COLS = 38;
   localparam int ROWS = 20;
   localparam int N    = COLS * ROWS;

   typedef struct packed {
      logic [7:0] d;
      logic [5:0] c;
      logic [4:0] r;
      logic       sof;
      logic       eof;
   } tile_t;

   logic       clk = 1'b0;
   logic       reset, start, abort, tile_ready;
   logic       busy, done, mem_chipselect, mem_clken, mem_write;
   logic [9:0] mem_address;
   logic [7:0] mem_writedata, mem_readdata, tile_data;
   logic [5:0] tile_col;
   logic [4:0] tile_row;
   logic       tile_valid, tile_sof, tile_eof;

   int    vectors = 0;
   int    errors  = 0;
   int    issued, popped;
   tile_t exp_q[$];
   tile_t held;
   logic  stalled;

   always #5 clk = ~clk;

   always @(posedge clk) mem_readdata <= mem_address[7:0];

   snake_mem_scanner #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(10)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .busy(busy), .done(done),
      .mem_address(mem_address), .mem_chipselect(mem_chipselect),
      .mem_clken(mem_clken), .mem_write(mem_write), .mem_writedata(mem_writedata),
      .mem_readdata(mem_readdata),
      .tile_valid(tile_valid), .tile_ready(tile_ready),
      .tile_data(tile_data), .tile_col(tile_col), .tile_row(tile_row),
      .tile_sof(tile_sof), .tile_eof(tile_eof)
   );

   task automatic load_expected();
      tile_t t;
      exp_q.delete();
      for (int i = 0; i < N; i++) begin
         t.d   = i[7:0];
         t.c   = 6'(i % COLS);
         t.r   = 5'(i / COLS);
         t.sof = (i == 0);
         t.eof = (i == N - 1);
         exp_q.push_back(t);
      end
      issued  = 0;
      popped  = 0;
      stalled = 1'b0;
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // One cycle: drive ready, sample outputs, pop scoreboard on a handshake.
   task automatic sb_cycle(input logic rdy, output logic hs, output logic dn, output tile_t got);
      tile_t e;
      @(negedge clk);
      tile_ready = rdy;
      #1;
      got = {tile_data, tile_col, tile_row, tile_sof, tile_eof};
      if (stalled) begin
         vectors++;
         if (!tile_valid || got !== held) begin
            errors++;
            $display("FAIL stall_hold: got valid=%0b %h required valid=1 %h", tile_valid, got, held);
         end
      end
      vectors++;
      if (mem_write !== 1'b0 || mem_clken !== 1'b1 || mem_writedata !== 8'h00) begin
         errors++;
         $display("FAIL mem_ties: got we=%0b ce=%0b wd=%h required 0 1 00", mem_write, mem_clken, mem_writedata);
      end
      if (mem_chipselect) issued++;
      hs = tile_valid && rdy;
      if (hs) begin
         popped++;
         vectors++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_tile: got %h required none", got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL tile_seq: got %h required %h", got, e);
            end
         end
      end
      vectors++;
      if (issued - popped > 2) begin
         errors++;
         $display("FAIL reads_ahead: got %0d required <=2", issued - popped);
      end
      stalled = tile_valid && !rdy;
      held    = got;
      dn      = done;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; abort = 1'b0; tile_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      vectors++;
      if ({busy, done, tile_valid, mem_chipselect} !== 4'b0 || mem_address !== 10'd0) begin
         errors++;
         $display("FAIL reset_state: got b=%0b d=%0b v=%0b cs=%0b a=%0d required 0 0 0 0 0",
                  busy, done, tile_valid, mem_chipselect, mem_address);
      end
      reset = 1'b0;
   endtask

   task automatic test_full_rate();
      logic hs, dn; tile_t g;
      int first_v = -1, done_idx = -1, ndone = 0, nhs = 0;
      load_expected();
      do_start();
      for (int j = 0; j < 770; j++) begin
         sb_cycle(1'b1, hs, dn, g);
         if (hs && first_v < 0) first_v = j;
         if (hs && nhs == 39) begin
            vectors++;
            if (g.c !== 6'd1 || g.r !== 5'd1 || g.d !== 8'h27) begin
               errors++;
               $display("FAIL tile39: got c=%0d r=%0d d=%h required 1 1 27", g.c, g.r, g.d);
            end
         end
         if (hs) nhs++;
         if (dn) begin ndone++; done_idx = j; end
      end
      vectors++;
      if (first_v != 2) begin errors++; $display("FAIL first_valid: got idx %0d required 2", first_v); end
      vectors++;
      if (done_idx != 762 || ndone != 1) begin
         errors++;
         $display("FAIL done_timing: got idx %0d count %0d required 762 1", done_idx, ndone);
      end
      vectors++;
      if (exp_q.size() != 0 || nhs != N) begin
         errors++;
         $display("FAIL full_count: got %0d tiles required %0d", nhs, N);
      end
      vectors++;
      if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_end: got %0b required 0", busy); end
   endtask

   task automatic test_random_ready();
      logic hs, dn; tile_t g;
      int ndone = 0, j = 0;
      load_expected();
      do_start();
      while (ndone == 0 && j < 5000) begin
         sb_cycle(1'($urandom_range(1)), hs, dn, g);
         if (j == 300) start = 1'b1;
         if (j == 301) start = 1'b0;
         if (dn) ndone++;
         j++;
      end
      for (int k = 0; k < 20; k++) begin
         sb_cycle(1'b1, hs, dn, g);
         if (dn) ndone++;
      end
      vectors++;
      if (ndone != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL random_ready: got done=%0d left=%0d required 1 0", ndone, exp_q.size());
      end
   endtask

   task automatic test_stall();
      logic hs, dn; tile_t g;
      int ndone = 0, j = 0;
      load_expected();
      do_start();
      for (int k = 0; k < 22; k++) sb_cycle(1'b0, hs, dn, g);
      vectors++;
      if (issued != 2 || !g.sof || tile_valid !== 1'b1) begin
         errors++;
         $display("FAIL stall_issue: got issued=%0d sof=%0b required 2 1", issued, g.sof);
      end
      while (ndone == 0 && j < 2000) begin
         sb_cycle(1'b1, hs, dn, g);
         if (dn) ndone++;
         j++;
      end
      vectors++;
      if (ndone != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL stall_resume: got done=%0d left=%0d required 1 0", ndone, exp_q.size());
      end
   endtask

   task automatic test_abort();
      logic hs, dn; tile_t g;
      int j = 0, ndone = 0;
      load_expected();
      do_start();
      while (popped < 100 && j < 500) begin sb_cycle(1'b1, hs, dn, g); j++; end
      abort = 1'b1;
      @(negedge clk);
      #1;
      vectors++;
      if (tile_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_next: got v=%0b b=%0b d=%0b required 0 0 0", tile_valid, busy, done);
      end
      abort = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      @(negedge clk);
      start = 1'b1; abort = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; abort = 1'b0;
      vectors++;
      if (busy !== 1'b0 || ndone != 0) begin
         errors++;
         $display("FAIL abort_wins: got busy=%0b dones=%0d required 0 0", busy, ndone);
      end
      load_expected();
      do_start();
      for (int k = 0; k < 12; k++) sb_cycle(1'b1, hs, dn, g);
      vectors++;
      if (popped != 10) begin errors++; $display("FAIL rescan_count: got %0d required 10", popped); end
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
   endtask

   task automatic test_reset_drain();
      logic hs, dn; tile_t g;
      int j = 0, ndone = 0;
      load_expected();
      do_start();
      while (popped < N - 1 && j < 1000) begin sb_cycle(1'b1, hs, dn, g); j++; end
      @(negedge clk);
      tile_ready = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      #1;
      vectors++;
      if ({busy, done, tile_valid, mem_chipselect} !== 4'b0 || mem_address !== 10'd0) begin
         errors++;
         $display("FAIL drain_reset: got b=%0b d=%0b v=%0b cs=%0b a=%0d required 0 0 0 0 0",
                  busy, done, tile_valid, mem_chipselect, mem_address);
      end
      reset = 1'b0;
      load_expected();
      do_start();
      j = 0;
      while (ndone == 0 && j < 1000) begin
         sb_cycle(1'b1, hs, dn, g);
         if (dn) ndone++;
         j++;
      end
      vectors++;
      if (ndone != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL post_reset_scan: got done=%0d left=%0d required 1 0", ndone, exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_full_rate();
      test_random_ready();
      test_stall();
      test_abort();
      test_reset_drain();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/snake_mem_scanner.md
SNAKE_MEM_SCANNER -- requirements
Module: snake_mem_scanner

Interface
REQ-001 SHALL have parameter COLS, default 38, tiles per grid row.
REQ-002 SHALL have parameter ROWS, default 20, grid rows; COLS*ROWS = 760 = RAM depth.
REQ-003 SHALL have parameter ADDR_W, default 10, RAM word-address width.
REQ-004 SHALL have port clk  in  1  single clock for all logic and the RAM read port.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle request to scan the full grid.
REQ-007 SHALL have port abort  in  1  terminates a scan in progress.
REQ-008 SHALL have port busy  out  1  high from scan acceptance until done or abort.
REQ-009 SHALL have port done  out  1  one-cycle pulse when the last tile has been accepted.
REQ-010 SHALL have port mem_address  out  ADDR_W  word address to the snake memory second port.
REQ-011 SHALL have port mem_chipselect  out  1  read-issue strobe.
REQ-012 SHALL have port mem_clken  out  1  clock enable for the RAM port, tied high.
REQ-013 SHALL have port mem_write  out  1  tied low; mem_writedata out 8, tied 0.
REQ-014 SHALL have port mem_readdata  in  8  RAM data, valid the cycle after the address is presented.
REQ-015 SHALL have port tile_valid/tile_ready  out/in  1  output stream handshake.
REQ-016 SHALL have port tile_data  out  8  tile code; tile_col out 6; tile_row out 5.
REQ-017 SHALL have port tile_sof/tile_eof  out  1  mark tile (0,0) and tile (COLS-1,ROWS-1).

Function
REQ-018 SHALL implement FSM IDLE, SCAN, DRAIN; busy = (state != IDLE).
REQ-019 IDLE: start sampled high -> SCAN, with issue address, column and row counters cleared; start is ignored outside IDLE.
REQ-020 SCAN: issue one read (mem_chipselect=1, mem_address=issue counter) per cycle, provided buffered tiles plus in-flight reads < 2.
REQ-021 Issue counter increments by 1 per issued read; column wraps COLS-1 -> 0 and increments row; a mul-free counter is required.
REQ-022 The read issued in cycle n SHALL be captured, with its column/row tag, into a 2-entry output buffer at the end of cycle n+1.
REQ-023 Issuing the read for address COLS*ROWS-1 -> DRAIN; no further reads are issued.
REQ-024 DRAIN: when the eof tile handshakes (tile_valid & tile_ready) -> IDLE with done=1 for exactly that next cycle.
REQ-025 A tile transfers only on tile_valid & tile_ready; while tile_valid=1 and tile_ready=0, tile_data/col/row/sof/eof SHALL be held stable.
REQ-026 Tiles SHALL be emitted in raster order, address 0..759, with no loss or duplication under any tile_ready pattern.
REQ-027 With tile_ready held high: start at edge k -> first tile_valid in cycle k+3; one tile per cycle thereafter; done in cycle k+763.
REQ-028 Simultaneous buffer push and pop SHALL be supported without a bubble.
REQ-029 tile_sof=1 only with tile (0,0); tile_eof=1 only with tile (COLS-1,ROWS-1).
REQ-030 abort in SCAN or DRAIN -> IDLE next cycle; buffer and in-flight read discarded; tile_valid=0; no done pulse; abort in IDLE has no effect.
REQ-031 start and abort high together in IDLE: abort wins, and the scan SHALL NOT start.
REQ-032 mem_address SHALL hold its last value when no read is issued; RAM contents SHALL never be written.

Reset
REQ-033 reset SHALL force IDLE, busy=0, done=0, tile_valid=0, mem_chipselect=0, mem_address=0, counters=0 and an empty buffer on the next clk edge.
REQ-034 reset mid-scan SHALL discard all pending tiles; start in the cycle after reset release SHALL begin a fresh scan from address 0.

Verification
REQ-035 RAM preloaded with data=addr[7:0]; start, tile_ready=1 -> 760 tiles in order; tile 39 is col 1, row 1, data 0x27; done at k+763.
REQ-036 tile_ready toggled randomly at 50% -> same 760-tile sequence, stable outputs while stalled, never more than 2 reads ahead.
REQ-037 tile_ready=0 for 20 cycles after the first tile_valid -> exactly 2 reads issued, tile (0,0) held, then resumes without loss.
REQ-038 abort at tile 100 -> tile_valid=0 and busy=0 next cycle, no done; a new start rescans from (0,0) with sof=1.
REQ-039 reset asserted in DRAIN -> all outputs at reset values next cycle; start pulse during busy ignored (only one done per scan).
